// File: rtl/frame_stage_buffer_pkg.sv
// Shared definitions for the frame staging buffer: FSM state encodings and frame constants.
package frame_stage_buffer_pkg;

    typedef enum logic [1:0] {
        FS_FILL  = 2'd0,
        FS_DROP  = 2'd1,
        FS_READY = 2'd2,
        FS_DRAIN = 2'd3
    } fs_state_e;

    localparam logic [15:0] FRAME_HDR_MAGIC       = 16'hF5A1;
    localparam int          FRAME_MAX_WORDS_LIMIT = 16383;

endpackage

// File: rtl/frame_stage_buffer_sfifo_fwft.sv
// Single-clock first-word-fall-through FIFO: rd_data presents the head word whenever empty=0.
module frame_stage_buffer_sfifo_fwft #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W:0]  wr_ptr;
    logic [ADDR_W:0]  rd_ptr;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_en && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en && !full)
            mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
    end

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                     (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign rd_data = mem[rd_ptr[ADDR_W-1:0]];

endmodule

// File: rtl/frame_stage_buffer.sv
// Store-and-forward single-frame buffer: collects one eop-terminated frame, then drains it with a known size.
// Optional FRAME_SEQ_EN prepends a {F5A1, seq} header word to every outgoing frame.
module frame_stage_buffer
    import frame_stage_buffer_pkg::*;
#(
    parameter int MAX_WORDS = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_in_data,
    input  logic        i_in_vld,
    input  logic        i_in_eop,
    output logic        o_in_rdy,
    output logic [31:0] o_out_data,
    output logic        o_out_vld,
    output logic        o_out_eop,
    input  logic        i_out_rdy,
    output logic        o_frame_ready,
    output logic [15:0] o_frame_size,
    output logic [7:0]  o_trunc_cnt
);

    localparam int          CAP   = (MAX_WORDS > FRAME_MAX_WORDS_LIMIT) ? FRAME_MAX_WORDS_LIMIT : MAX_WORDS;
    localparam logic [15:0] CAP_W = 16'(CAP);

    fs_state_e   state;
    fs_state_e   state_nxt;
    logic [15:0] wr_cnt;
    logic [15:0] rd_cnt;
    logic [15:0] len;
    logic [15:0] size_val;
    logic [31:0] fifo_dout;
    logic        fifo_wr;
    logic        fifo_rd;
    logic        fifo_full;
    logic        fifo_empty;
    logic        in_acc;
    logic        out_acc;
    logic        last_word;
    logic        frame_done;
    logic        hit_cap;

`ifdef FRAME_SEQ_EN
    logic [15:0] seq;
    assign size_val = len + 16'd1;
`else
    assign size_val = len;
`endif

    assign in_acc     = i_in_vld & o_in_rdy;
    assign out_acc    = o_out_vld & i_out_rdy;
    assign last_word  = (rd_cnt + 16'd1 == len);
    assign frame_done = out_acc & o_out_eop;
    assign hit_cap    = (wr_cnt == CAP_W - 16'd1);

    frame_stage_buffer_sfifo_fwft #(
        .WIDTH  (32),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (frame_done),
        .wr_en   (fifo_wr),
        .wr_data (i_in_data),
        .rd_en   (fifo_rd),
        .rd_data (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= FS_FILL;
        else
            state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first, so no path through the case can infer a latch.
    always_comb begin
        state_nxt     = state;
        o_in_rdy      = 1'b0;
        o_out_data    = '0;
        o_out_vld     = 1'b0;
        o_out_eop     = 1'b0;
        o_frame_ready = 1'b0;
        o_frame_size  = '0;
        fifo_wr       = 1'b0;
        fifo_rd       = 1'b0;

        unique case (state)
            FS_FILL: begin
                o_in_rdy = !fifo_full && !rst;
                fifo_wr  = in_acc;
                if (in_acc) begin
                    if (i_in_eop)
                        state_nxt = FS_READY;
                    else if (hit_cap)
                        state_nxt = FS_DROP;
                end
            end

            FS_DROP: begin
                o_in_rdy = !rst;
                if (in_acc && i_in_eop)
                    state_nxt = FS_READY;
            end

            FS_READY: begin
                o_frame_ready = 1'b1;
                o_frame_size  = size_val;
`ifdef FRAME_SEQ_EN
                o_out_vld  = 1'b1;
                o_out_data = {FRAME_HDR_MAGIC, seq};
                if (out_acc)
                    state_nxt = FS_DRAIN;
`else
                o_out_vld  = !fifo_empty;
                o_out_data = fifo_dout;
                o_out_eop  = last_word;
                fifo_rd    = out_acc;
                // A one-word frame finishes on this very handshake.
                if (out_acc)
                    state_nxt = last_word ? FS_FILL : FS_DRAIN;
`endif
            end

            FS_DRAIN: begin
                o_out_vld  = !fifo_empty;
                o_out_data = fifo_dout;
                o_out_eop  = last_word;
                fifo_rd    = out_acc;
                if (out_acc && last_word)
                    state_nxt = FS_FILL;
            end

            default: state_nxt = FS_FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            len         <= '0;
            o_trunc_cnt <= '0;
        end else begin
            if (frame_done) begin
                wr_cnt <= '0;
                rd_cnt <= '0;
            end else begin
                if (state == FS_FILL && in_acc)
                    wr_cnt <= wr_cnt + 16'd1;
                if (fifo_rd)
                    rd_cnt <= rd_cnt + 16'd1;
            end

            // Eop takes priority over the capacity limit: eop on word CAP is a normal full frame.
            if (state == FS_FILL && in_acc) begin
                if (i_in_eop) begin
                    len <= wr_cnt + 16'd1;
                end else if (hit_cap) begin
                    len <= CAP_W;
                    if (o_trunc_cnt != 8'hFF)
                        o_trunc_cnt <= o_trunc_cnt + 8'd1;
                end
            end
        end
    end

`ifdef FRAME_SEQ_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            seq <= '0;
        else if (frame_done)
            seq <= seq + 16'd1;
    end
`endif

endmodule
